controlador_bus: RTL and testbench
==================================

# controlador_bus

Bus master for the CPUCR system memory bus: converts single-cycle read/write requests from the CPU core into properly sequenced cycles on the shared `Direccion`/`Datos`/`LE` bus. It owns the bidirectional data-bus driver and the write strobe, and inserts configurable wait states. It sits between the CPU core and the main 64 KiB memory, which drives `Datos` while `LE=1` and writes on the falling edge of `LE`.

## Interface
- `ESPERA`, default 1: read wait cycles (1..15) between address presentation and data capture.
- `ESCRITURA`, default 2: cycles `LE` is held low during a write (1..15).
- `clk`  input  1  system clock, all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `req`  input  1  core request, sampled only in IDLE.
- `we`  input  1  1 = write, 0 = read; sampled with `req`.
- `dir_in`  input  16  request address.
- `dato_out`  input  8  write data.
- `dato_in`  output  8  last read data, registered.
- `listo`  output  1  one-cycle completion pulse.
- `ocupado`  output  1  high from acceptance until the cycle `listo` is high, inclusive.
- `error`  output  1  one-cycle pulse, protected-write rejection (see Configuration).
- `Direccion`  output  16  memory address bus, registered.
- `LE`  output  1  1 = read / bus idle, 0 = write strobe, registered.
- `Datos`  inout  8  data bus; driven with the write-data register exactly when `LE=0`, else `8'bZ`.

## Operation
- States: IDLE, LEER, PREP, ESCRIBIR, RECUP, FIN.
- IDLE: `LE=1`, `Datos` released. When `req=1`, latch `dir_in` into `Direccion`, `dato_out` into the write register, and `we`; assert `ocupado`; go to LEER if `we=0`, else to PREP.
- LEER: stay `ESPERA` cycles. On the last cycle, capture `Datos` into `dato_in`, then go to FIN.
- PREP: stay 1 cycle with `LE=1` for address setup, then go to ESCRIBIR.
- ESCRIBIR: `LE=0` and `Datos` driven for `ESCRITURA` cycles, then go to RECUP.
- RECUP: `LE=1` and `Datos` released for 1 cycle of address hold, then go to FIN.
- FIN: `listo=1` for one cycle, then return to IDLE with `ocupado=0`.
- `req` outside IDLE is ignored. No queuing: the core must re-request after `listo`.
- `Direccion` holds its value after a cycle until the next acceptance.
- `dato_in` is unchanged by write cycles.
- A single wait counter of 4 bits reloads on every state entry.
- Reset values: state IDLE, `Direccion=16'h0000`, `LE=1`, `Datos` Z, `dato_in=8'h00`, `listo=0`, `ocupado=0`, `error=0`.
- Reset mid-cycle, including during ESCRIBIR: on that edge `LE` goes to 1 and `Datos` is released, and no `listo` is generated.

## Timing
- Acceptance edge is T0. The registers are updated at T0.
- Read: data is captured at edge T0+`ESPERA`. `listo` is high in the cycle after T0+`ESPERA`. Total time is `ESPERA`+2 cycles from the `req` sample.
- Write: `LE` falls at edge T0+1 and rises at edge T0+1+`ESCRITURA`. `listo` is high in the cycle after T0+2+`ESCRITURA`.
- A back-to-back request is accepted at the earliest one cycle after `listo`.
- The `Datos` drive enable is the `LE` flop itself, inverted. There is no separate enable flop, so memory and controller never drive the bus at the same time.

## Configuration
- `CTRL_BUS_PROTEGE_EN` defined:
  - A write with `dir_in < 16'h0100` (program page) is rejected: it goes IDLE→FIN with no `LE` pulse and no drive on `Datos`.
  - `error` and `listo` are both asserted in the FIN cycle.
  - `Direccion` is still updated.
- `CTRL_BUS_PROTEGE_EN` undefined: all writes proceed normally, and `error` is tied to 0.

## Test plan
- Reset: hold `reset` 2 cycles → `LE=1`, `Datos` Z, `listo=0`, `ocupado=0`, `Direccion=0`, `dato_in=0`.
- Read, `ESPERA=1`, memory preloaded with `M[0]=8'h06` → `dato_in=8'h06`, `listo` high exactly 2 cycles after the `req` edge, `LE` never 0.
- Write `8'h42` to `16'h1000`, then read `16'h1000` → `LE` low exactly `ESCRITURA` cycles, `Datos=8'h42` only while `LE=0`, read returns `8'h42`.
- `req` pulsed again during a write → ignored. Exactly one `listo`, and memory at the second request's address is unchanged.
- `reset` asserted in the 1st ESCRIBIR cycle → `LE=1` and `Datos` Z at that edge, no `listo`, next read accepted normally.
- With `CTRL_BUS_PROTEGE_EN`, write `8'hFF` to `16'h0007` → `error` and `listo` pulse together, `LE` stays 1, `M[7]` unchanged. Without the macro, `M[7]=8'hFF` and `error=0`.

Source files
------------

// File: rtl/controlador_bus.sv
// controlador_bus: CPUCR memory bus master. Turns single-cycle core requests
// into sequenced Direccion/Datos/LE cycles with configurable wait states.
// Optional feature macro: CTRL_BUS_PROTEGE_EN (reject writes to the program page < 16'h0100).
module controlador_bus #(
  parameter int unsigned ESPERA    = 1,
  parameter int unsigned ESCRITURA = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] dir_in,
  input  logic [7:0]  dato_out,
  output logic [7:0]  dato_in,
  output logic        listo,
  output logic        ocupado,
  output logic        error,
  output logic [15:0] Direccion,
  output logic        LE,
  inout  wire  [7:0]  Datos
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LEER     = 3'd1;
  localparam logic [2:0] PREP     = 3'd2;
  localparam logic [2:0] ESCRIBIR = 3'd3;
  localparam logic [2:0] RECUP    = 3'd4;
  localparam logic [2:0] FIN      = 3'd5;

  localparam logic [CW-1:0] CARGA_LEER = CW'(ESPERA - 1);
  localparam logic [CW-1:0] CARGA_ESCR = CW'(ESCRITURA - 1);

  logic [2:0]    state;
  logic [2:0]    state_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic [AW-1:0] dir_d;
  logic [DW-1:0] wdata;
  logic [DW-1:0] wdata_d;
  logic [DW-1:0] dato_in_d;
  logic          rechazo;

  // Bus driven only while the LE flop is low; memory owns it otherwise.
  assign Datos = LE ? {DW{1'bz}} : wdata;

`ifdef CTRL_BUS_PROTEGE_EN
  // Writes into the program page are turned away without touching the bus.
  assign rechazo = we && (dir_in < 16'h0100);

  // Rejection pulse lines up with the FIN cycle of the rejected write.
  always_ff @(posedge clk) begin
    if (reset) begin
      error <= 1'b0;
    end else begin
      error <= (state == IDLE) && req && rechazo;
    end
  end
`else
  assign rechazo = 1'b0;
  assign error   = 1'b0;
`endif

  // Next-state, counter and data-path next values.
  always_comb begin
    state_d   = state;
    cnt_d     = (cnt != '0) ? cnt - CW'(1) : cnt;
    dir_d     = Direccion;
    wdata_d   = wdata;
    dato_in_d = dato_in;
    case (state)
      IDLE: begin
        if (req) begin
          dir_d   = dir_in;
          wdata_d = dato_out;
          if (!we) begin
            state_d = LEER;
          end else if (rechazo) begin
            state_d = FIN;
          end else begin
            state_d = PREP;
          end
        end
      end
      LEER: begin
        if (cnt == '0) begin
          dato_in_d = Datos;
          state_d   = FIN;
        end
      end
      PREP:     state_d = ESCRIBIR;
      ESCRIBIR: if (cnt == '0) state_d = RECUP;
      RECUP:    state_d = FIN;
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // The single wait counter reloads whenever a new state is entered.
    if (state_d != state) begin
      case (state_d)
        LEER:     cnt_d = CARGA_LEER;
        ESCRIBIR: cnt_d = CARGA_ESCR;
        default:  cnt_d = '0;
      endcase
    end
  end

  // State register and registered bus/handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      Direccion <= '0;
      wdata     <= '0;
      dato_in   <= '0;
      listo     <= 1'b0;
      ocupado   <= 1'b0;
      LE        <= 1'b1;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      Direccion <= dir_d;
      wdata     <= wdata_d;
      dato_in   <= dato_in_d;
      listo     <= (state_d == FIN);
      ocupado   <= (state_d != IDLE);
      LE        <= (state_d != ESCRIBIR);
    end
  end

endmodule

// File: tb/tb_controlador_bus.sv
// tb_controlador_bus: randomized + directed bench with a transaction-level
// timeline model of controlador_bus and an attached 64 KiB memory.
module tb_controlador_bus;

  localparam int unsigned EP = 1;
  localparam int unsigned EC = 2;
`ifdef CTRL_BUS_PROTEGE_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [15:0] dir_in;
  logic [7:0]  dato_out;
  logic [7:0]  dato_in;
  logic        listo;
  logic        ocupado;
  logic        error;
  logic [15:0] Direccion;
  logic        LE;
  wire  [7:0]  Datos;

  logic [7:0] mem     [0:65535];
  logic [7:0] exp_mem [0:65535];

  int checks = 0;
  int errors = 0;

  controlador_bus #(.ESPERA(EP), .ESCRITURA(EC)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .dir_in(dir_in),
    .dato_out(dato_out), .dato_in(dato_in), .listo(listo), .ocupado(ocupado),
    .error(error), .Direccion(Direccion), .LE(LE), .Datos(Datos)
  );

  always #5 clk = ~clk;

  // Memory: drives the bus while LE=1, stores on the falling edge of LE.
  assign Datos = LE ? mem[Direccion] : 8'hzz;
  initial begin
    forever begin
      @(negedge LE);
      #1;
      if (LE == 1'b0) mem[Direccion] = Datos;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Expected per-cycle view of the outputs.
  typedef struct packed {
    logic        ocup;
    logic        lst;
    logic        err;
    logic        le;
    logic [15:0] dir;
    logic [7:0]  din;
    logic [7:0]  wdat;
    logic        commit;
  } rec_t;

  function automatic rec_t mk(logic o, logic l, logic e, logic le, logic [15:0] d,
                              logic [7:0] di, logic [7:0] wd, logic cm);
    rec_t r;
    r.ocup = o; r.lst = l; r.err = e; r.le = le;
    r.dir = d; r.din = di; r.wdat = wd; r.commit = cm;
    return r;
  endfunction

  rec_t q[$];
  rec_t cur = '0;
  bit   cmp_en = 1'b0;

  // Model: on acceptance, lay out the whole cycle timeline from the timing rules.
  initial begin
    logic [15:0] last_dir;
    logic [7:0]  last_din;
    last_dir = '0;
    last_din = '0;
    forever begin
      @(posedge clk);
      if (reset) begin
        q.delete();
        last_dir = '0;
        last_din = '0;
        cur = mk(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 8'h0, 8'h0, 1'b0);
      end else begin
        if (!cur.ocup && req) begin
          if (!we) begin
            for (int i = 0; i < int'(EP); i++)
              q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, dir_in, last_din, dato_out, 1'b0));
            q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, dir_in, exp_mem[dir_in], dato_out, 1'b0));
          end else if (PROT && dir_in < 16'h0100) begin
            q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, dir_in, last_din, dato_out, 1'b0));
          end else begin
            q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, dir_in, last_din, dato_out, 1'b0));
            for (int i = 0; i < int'(EC); i++)
              q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, dir_in, last_din, dato_out, (i == 0)));
            q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, dir_in, last_din, dato_out, 1'b0));
            q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, dir_in, last_din, dato_out, 1'b0));
          end
        end
        if (q.size() > 0) begin
          cur = q.pop_front();
          if (cur.commit) exp_mem[cur.dir] = cur.wdat;
        end else begin
          cur = mk(1'b0, 1'b0, 1'b0, 1'b1, last_dir, last_din, cur.wdat, 1'b0);
        end
        last_dir = cur.dir;
        last_din = cur.din;
      end
      cmp_en = 1'b1;
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("ocupado",   16'(ocupado),   16'(cur.ocup));
        chk("listo",     16'(listo),     16'(cur.lst));
        chk("error",     16'(error),     16'(cur.err));
        chk("LE",        16'(LE),        16'(cur.le));
        chk("Direccion", Direccion,      cur.dir);
        chk("dato_in",   16'(dato_in),   16'(cur.din));
        chk("Datos",     16'(Datos),     16'(cur.le ? exp_mem[cur.dir] : cur.wdat));
      end
    end
  end

  // One request from a falling edge; counts cycles to listo and LE-low cycles.
  task automatic txn(input logic w, input logic [15:0] a, input logic [7:0] d,
                     output int lat, output int lows);
    req = 1'b1; we = w; dir_in = a; dato_out = d;
    lat = 0; lows = 0;
    do begin
      @(negedge clk);
      req = 1'b0;
      lat++;
      if (LE == 1'b0) begin
        lows++;
        chk("strobe_data", 16'(Datos), 16'(d));
      end
    end while (listo !== 1'b1 && lat < 64);
  endtask

  initial begin
    int lat, lows, n;
    reset = 1'b1; req = 1'b0; we = 1'b0; dir_in = '0; dato_out = '0;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      exp_mem[i] = mem[i];
    end
    mem[0] = 8'h06;          exp_mem[0] = 8'h06;
    mem[7] = 8'h3C;          exp_mem[7] = 8'h3C;
    mem[16'h3000] = 8'h5A;   exp_mem[16'h3000] = 8'h5A;

    repeat (2) @(negedge clk);
    chk("rst_LE", 16'(LE), 16'h1);
    chk("rst_dir", Direccion, 16'h0000);
    chk("rst_dato_in", 16'(dato_in), 16'h00);
    chk("rst_ocupado", 16'(ocupado), 16'h0);
    chk("rst_listo", 16'(listo), 16'h0);
    reset = 1'b0;
    @(negedge clk);

    // Read M[0]
    txn(1'b0, 16'h0000, 8'h00, lat, lows);
    chk("rd_lat", 16'(lat), 16'(EP + 1));
    chk("rd_data", 16'(dato_in), 16'h06);
    chk("rd_le_low", 16'(lows), 16'h0);
    @(negedge clk);

    // Write 42 to 1000, read it back
    txn(1'b1, 16'h1000, 8'h42, lat, lows);
    chk("wr_lat", 16'(lat), 16'(EC + 3));
    chk("wr_le_low", 16'(lows), 16'(EC));
    chk("wr_keeps_dato_in", 16'(dato_in), 16'h06);
    @(negedge clk);
    txn(1'b0, 16'h1000, 8'h00, lat, lows);
    chk("rdback_data", 16'(dato_in), 16'h42);
    @(negedge clk);

    // Second request during a write is ignored
    req = 1'b1; we = 1'b1; dir_in = 16'h2000; dato_out = 8'h11;
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; dir_in = 16'h3000; dato_out = 8'h99;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req = 1'b0;
      if (listo) n++;
    end
    chk("ignored_listo_count", 16'(n), 16'h1);
    chk("ignored_mem3000", 16'(mem[16'h3000]), 16'h5A);
    chk("first_mem2000", 16'(mem[16'h2000]), 16'h11);

    // Reset in the first ESCRIBIR cycle
    req = 1'b1; we = 1'b1; dir_in = 16'h4000; dato_out = 8'h77;
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    chk("abort_strobe_on", 16'(LE), 16'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_LE", 16'(LE), 16'h1);
    chk("abort_listo", 16'(listo), 16'h0);
    chk("abort_ocupado", 16'(ocupado), 16'h0);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (listo) n++;
    end
    chk("abort_no_listo", 16'(n), 16'h0);
    txn(1'b0, 16'h1000, 8'h00, lat, lows);
    chk("post_abort_lat", 16'(lat), 16'(EP + 1));
    chk("post_abort_data", 16'(dato_in), 16'h42);
    @(negedge clk);

    // Program-page write
    txn(1'b1, 16'h0007, 8'hFF, lat, lows);
    chk("prot_lat", 16'(lat), PROT ? 16'h1 : 16'(EC + 3));
    chk("prot_error", 16'(error), PROT ? 16'h1 : 16'h0);
    chk("prot_le_low", 16'(lows), PROT ? 16'h0 : 16'(EC));
    chk("prot_dir", Direccion, 16'h0007);
    @(negedge clk);
    chk("prot_mem7", 16'(mem[7]), PROT ? 16'h3C : 16'hFF);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      reset    = ($urandom_range(0, 199) == 0);
      req      = ($urandom_range(0, 2) == 0);
      we       = 1'($urandom_range(0, 1));
      dir_in   = ($urandom_range(0, 2) == 0) ? {8'h00, 8'($urandom)} : 16'($urandom);
      dato_out = 8'($urandom);
      @(negedge clk);
    end
    reset = 1'b0; req = 1'b0;
    repeat (EC + 8) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
